// File: rtl/ahb_addr_decoder_pkg.sv
`default_nettype none
// ============================================================================
// ahb_addr_decoder_pkg : shared AHB constants, default address map and types
// Rev 1.0
// ============================================================================
package ahb_addr_decoder_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_SLAVES = 4;

  // Half-open regions [BASE, HIGH)
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR [NUM_SLAVES] = '{
    32'h0000_0000, 32'h0000_1000, 32'h1000_0000, 32'h4000_0000
  };
  localparam logic [ADDR_WIDTH-1:0] HIGH_ADDR [NUM_SLAVES] = '{
    32'h0000_1000, 32'h0000_2000, 32'h2000_0000, 32'h4000_0100
  };

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef logic [1:0] ds_state_t;
  localparam ds_state_t DS_IDLE = 2'd0;
  localparam ds_state_t DS_ERR1 = 2'd1;
  localparam ds_state_t DS_ERR2 = 2'd2;

  function automatic logic is_active(input htrans_t t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_addr_decoder_if.sv
`default_nettype none
// ============================================================================
// ahb_addr_decoder_if : address-phase inputs, slave responses and muxed outputs
// Rev 1.0
// ============================================================================
interface ahb_addr_decoder_if #(
  parameter int NUM_SLAVES = ahb_addr_decoder_pkg::NUM_SLAVES,
  parameter int ADDR_WIDTH = ahb_addr_decoder_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = ahb_addr_decoder_pkg::DATA_WIDTH
);
  import ahb_addr_decoder_pkg::*;

  logic [ADDR_WIDTH-1:0]                 Haddr;
  htrans_t                               Htrans;
  logic [NUM_SLAVES-1:0]                 Region_en;
  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] Hrdata_s;
  logic [NUM_SLAVES-1:0]                 Hreadyout_s;
  logic [NUM_SLAVES-1:0]                 Hresp_s;
  logic [NUM_SLAVES-1:0]                 Hsel;
  logic                                  Hsel_default;
  logic [DATA_WIDTH-1:0]                 Hrdata;
  logic                                  Hready;
  logic                                  Hresp;
  logic [7:0]                            Err_count;

  modport master (
    output Haddr, Htrans, Region_en, Hrdata_s, Hreadyout_s, Hresp_s,
    input  Hsel, Hsel_default, Hrdata, Hready, Hresp, Err_count
  );

  modport slave (
    input  Haddr, Htrans, Region_en, Hrdata_s, Hreadyout_s, Hresp_s,
    output Hsel, Hsel_default, Hrdata, Hready, Hresp, Err_count
  );

endinterface
`default_nettype wire

// File: rtl/ahb_default_slave.sv
`default_nettype none
// ============================================================================
// ahb_default_slave : two-cycle ERROR responder for unmapped transfers
// Rev 1.0
// ============================================================================
module ahb_default_slave
  import ahb_addr_decoder_pkg::*;
(
  input  wire          Hclk,
  input  wire          Hresetn,
  input  wire          i_hready,
  input  wire          i_hsel_default,
  input  wire htrans_t i_htrans,
  output logic         o_hready,
  output logic         o_hresp,
  output logic [7:0]   o_err_count
);

  ds_state_t  r_state;
  ds_state_t  w_state_nxt;
  logic       w_qualify;
  logic [7:0] r_err_count;

  assign w_qualify = i_hready && i_hsel_default && is_active(i_htrans);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DS_IDLE: if (w_qualify) w_state_nxt = DS_ERR1;
      DS_ERR1: w_state_nxt = DS_ERR2;
      DS_ERR2: w_state_nxt = w_qualify ? DS_ERR1 : DS_IDLE;
      default: w_state_nxt = DS_IDLE;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state     <= DS_IDLE;
      r_err_count <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt == DS_ERR1 && r_err_count != 8'hFF)
        r_err_count <= r_err_count + 8'd1;
    end
  end

  // ERROR needs a wait cycle first, then a ready cycle, both flagged ERROR
  assign o_hready    = (r_state != DS_ERR1);
  assign o_hresp     = (r_state == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;
  assign o_err_count = r_err_count;

endmodule
`default_nettype wire

// File: rtl/ahb_addr_decoder.sv
`default_nettype none
// ============================================================================
// ahb_addr_decoder : region decode, data-phase select and response mux
// Rev 1.0
// ============================================================================
module ahb_addr_decoder #(
  parameter int NUM_SLAVES = ahb_addr_decoder_pkg::NUM_SLAVES,
  parameter int ADDR_WIDTH = ahb_addr_decoder_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = ahb_addr_decoder_pkg::DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR [NUM_SLAVES] = ahb_addr_decoder_pkg::BASE_ADDR,
  parameter logic [ADDR_WIDTH-1:0] HIGH_ADDR [NUM_SLAVES] = ahb_addr_decoder_pkg::HIGH_ADDR
) (
  input wire                Hclk,
  input wire                Hresetn,
  ahb_addr_decoder_if.slave bus
);
  import ahb_addr_decoder_pkg::*;

  localparam int c_idx_w = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  logic [NUM_SLAVES-1:0] w_match;
  logic [NUM_SLAVES-1:0] w_sel;
  logic                  w_sel_default;
  logic [c_idx_w-1:0]    w_idx;
  logic [c_idx_w-1:0]    r_dp_idx;
  logic                  r_dp_default;
  logic                  w_hready;
  logic                  w_hresp;
  logic [DATA_WIDTH-1:0] w_hrdata;
  logic                  w_ds_hready;
  logic                  w_ds_hresp;
  logic [7:0]            w_err_count;

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_region
    assign w_match[i] = bus.Region_en[i] &&
                        (bus.Haddr >= BASE_ADDR[i]) &&
                        (bus.Haddr <  HIGH_ADDR[i]);
  end

  // Isolating the lowest set bit gives lowest-index priority on overlaps
  assign w_sel         = w_match & (~w_match + NUM_SLAVES'(1));
  assign w_sel_default = (w_sel == '0);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (w_sel[i]) w_idx = c_idx_w'(i);
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_dp_default <= 1'b1;
      r_dp_idx     <= '0;
    end else if (w_hready) begin
      r_dp_default <= w_sel_default;
      r_dp_idx     <= w_idx;
    end
  end

  always_comb begin
    w_hready = w_ds_hready;
    w_hresp  = w_ds_hresp;
    w_hrdata = '0;
    if (!r_dp_default) begin
      w_hready = bus.Hreadyout_s[r_dp_idx];
      w_hresp  = bus.Hresp_s[r_dp_idx];
      w_hrdata = bus.Hrdata_s[r_dp_idx];
    end
  end

  ahb_default_slave u_default_slave (
    .Hclk           (Hclk),
    .Hresetn        (Hresetn),
    .i_hready       (w_hready),
    .i_hsel_default (w_sel_default),
    .i_htrans       (bus.Htrans),
    .o_hready       (w_ds_hready),
    .o_hresp        (w_ds_hresp),
    .o_err_count    (w_err_count)
  );

  assign bus.Hsel         = w_sel;
  assign bus.Hsel_default = w_sel_default;
  assign bus.Hready       = w_hready;
  assign bus.Hresp        = w_hresp;
  assign bus.Hrdata       = w_hrdata;
  assign bus.Err_count    = w_err_count;

endmodule
`default_nettype wire

// File: tb/tb_ahb_addr_decoder.sv
`default_nettype none
// ============================================================================
// tb_ahb_addr_decoder : directed + randomized checks against a behavioural model
// Rev 1.0
// ============================================================================
module tb_ahb_addr_decoder;
  import ahb_addr_decoder_pkg::*;

  logic Hclk = 1'b0;
  logic Hresetn;
  always #5 Hclk = ~Hclk;

  ahb_addr_decoder_if bus ();
  ahb_addr_decoder dut (.Hclk(Hclk), .Hresetn(Hresetn), .bus(bus));

  // Second instance with an overlapping map to exercise priority
  localparam logic [31:0] OV_LO [4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0100, 32'h0000_0000};
  localparam logic [31:0] OV_HI [4] = '{32'h0000_0200, 32'h0000_0400, 32'h0000_0300, 32'hFFFF_FFFF};
  ahb_addr_decoder_if bus_ov ();
  ahb_addr_decoder #(.BASE_ADDR(OV_LO), .HIGH_ADDR(OV_HI))
    dut_ov (.Hclk(Hclk), .Hresetn(Hresetn), .bus(bus_ov));

  localparam logic [31:0] MAP_LO [4] = '{32'h0000_0000, 32'h0000_1000, 32'h1000_0000, 32'h4000_0000};
  localparam logic [31:0] MAP_HI [4] = '{32'h0000_1000, 32'h0000_2000, 32'h2000_0000, 32'h4000_0100};

  int n_vec, n_err;
  int m_dp;        // data-phase owner: slave index, or -1 for the default slave
  int m_err_left;  // remaining cycles of an ERROR response (2 = wait, 1 = final)
  int m_cnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a, input logic [3:0] en,
                                    input logic [31:0] lo [4], input logic [31:0] hi [4]);
    for (int i = 0; i < 4; i++)
      if (en[i] && a >= lo[i] && a < hi[i]) return i;
    return -1;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [1:0] t,
                       input logic [3:0] en, input logic [3:0] rdy);
    bus.Haddr       = a;
    bus.Htrans      = htrans_t'(t);
    bus.Region_en   = en;
    bus.Hreadyout_s = rdy;
    bus.Hresp_s     = '0;
    for (int i = 0; i < 4; i++) bus.Hrdata_s[i] = $urandom;
  endtask

  task automatic tick();
    int d;
    logic e_rdy, e_resp, act_trans;
    logic [31:0] e_rd;
    #1;
    d = ref_decode(bus.Haddr, bus.Region_en, MAP_LO, MAP_HI);
    act_trans = bus.Htrans[1];
    chk("hsel", bus.Hsel, (d < 0) ? 32'd0 : (32'd1 << d));
    chk("hsel_default", bus.Hsel_default, (d < 0) ? 32'd1 : 32'd0);
    if (m_dp >= 0) begin
      e_rdy  = bus.Hreadyout_s[m_dp];
      e_resp = bus.Hresp_s[m_dp];
      e_rd   = bus.Hrdata_s[m_dp];
    end else begin
      e_rdy  = (m_err_left != 2);
      e_resp = (m_err_left != 0);
      e_rd   = '0;
    end
    chk("hready", bus.Hready, e_rdy);
    chk("hresp", bus.Hresp, e_resp);
    chk("hrdata", bus.Hrdata, e_rd);
    chk("err_count", bus.Err_count, m_cnt);
    @(posedge Hclk);
    if (Hresetn) begin
      if (e_rdy) begin
        m_dp = d;
        if (d < 0 && act_trans) begin
          m_err_left = 2;
          if (m_cnt < 255) m_cnt++;
        end else begin
          m_err_left = 0;
        end
      end else if (m_err_left > 0) begin
        m_err_left--;
      end
    end
    @(negedge Hclk);
  endtask

  task automatic model_reset();
    m_dp = -1; m_err_left = 0; m_cnt = 0;
  endtask

  logic [31:0] ra;
  logic [3:0]  ren, rrdy;
  int          rr, rk, dov;

  initial begin
    n_vec = 0; n_err = 0;
    model_reset();
    Hresetn = 1'b0;
    bus_ov.Htrans = HTRANS_IDLE; bus_ov.Hreadyout_s = '1;
    bus_ov.Hresp_s = '0; bus_ov.Hrdata_s = '0;
    bus_ov.Haddr = '0; bus_ov.Region_en = '1;
    drive(32'h0, 2'd2, 4'hF, 4'hF);
    @(negedge Hclk);
    tick(); tick();
    Hresetn = 1'b1;

    // Region boundaries
    drive(32'h0000_0FFF, 2'd0, 4'hF, 4'hF); tick();
    drive(32'h0000_1000, 2'd0, 4'hF, 4'hF); tick();
    drive(32'h4000_0100, 2'd0, 4'hF, 4'hF); #1;
    chk("boundary_high_sel", bus.Hsel, 4'b0000);
    chk("boundary_high_default", bus.Hsel_default, 1'b1);
    tick();

    // Back-to-back unmapped NONSEQ
    drive(32'h3000_0000, 2'd2, 4'hF, 4'hF); tick();
    chk("err1_hready", bus.Hready, 1'b0);
    chk("err1_hresp", bus.Hresp, 1'b1);
    tick();
    chk("err2_hready", bus.Hready, 1'b1);
    chk("err2_count", bus.Err_count, 8'd1);
    drive(32'h3000_0000, 2'd2, 4'hF, 4'hF); tick();
    drive(32'h3000_0004, 2'd3, 4'hF, 4'hF); tick();
    drive(32'h0, 2'd0, 4'hF, 4'hF); tick();
    chk("second_err_count", bus.Err_count, 8'd2);
    tick();

    // Stalled slave 2 while the address moves to slave 0
    drive(32'h1000_0000, 2'd2, 4'hF, 4'b1011); tick();
    for (int k = 0; k < 3; k++) begin
      drive(32'h0000_0000 + 32'(k * 4), 2'd2, 4'hF, 4'b1011); tick();
    end
    drive(32'h0000_0010, 2'd2, 4'hF, 4'hF); tick();
    drive(32'h0, 2'd0, 4'hF, 4'hF); tick(); tick();

    // Region 0 disabled, IDLE/BUSY to default, all regions disabled
    drive(32'h0000_0010, 2'd0, 4'b1110, 4'hF); tick(); tick();
    drive(32'h0000_0010, 2'd1, 4'b1110, 4'hF); tick(); tick();
    drive(32'h1000_0000, 2'd0, 4'b0000, 4'hF); tick(); tick();

    // Reset in the middle of an ERROR response
    drive(32'h3000_0000, 2'd2, 4'hF, 4'hF); tick();
    Hresetn = 1'b0; #1;
    chk("rst_hready", bus.Hready, 1'b1);
    chk("rst_hresp", bus.Hresp, 1'b0);
    chk("rst_errcnt", bus.Err_count, 8'd0);
    model_reset();
    drive(32'h0, 2'd0, 4'hF, 4'hF); tick();
    Hresetn = 1'b1;
    tick(); tick();

    // Saturation of the error counter
    for (int k = 0; k < 300; k++) begin
      drive(32'h3000_0000 | ($urandom & 32'h0FFF_FFFC), 2'd2, 4'hF, 4'hF); tick(); tick();
    end
    drive(32'h0, 2'd0, 4'hF, 4'hF); tick(); tick();
    chk("err_saturate", bus.Err_count, 8'd255);

    // Randomized traffic biased towards region edges
    for (int n = 0; n < 2000; n++) begin
      rr = $urandom_range(0, 3);
      rk = $urandom_range(0, 5);
      case (rk)
        0: ra = MAP_LO[rr];
        1: ra = MAP_HI[rr];
        2: ra = MAP_HI[rr] - 32'd1;
        3: ra = MAP_LO[rr] - 32'd1;
        default: ra = $urandom;
      endcase
      ren = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      for (int i = 0; i < 4; i++) rrdy[i] = ($urandom_range(0, 3) != 0);
      drive(ra, 2'($urandom), ren, rrdy);
      bus.Hresp_s = 4'($urandom);
      tick();
    end

    // Overlap priority on the second instance
    for (int n = 0; n < 200; n++) begin
      bus_ov.Haddr     = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 32'h500));
      bus_ov.Region_en = 4'($urandom);
      #1;
      dov = ref_decode(bus_ov.Haddr, bus_ov.Region_en, OV_LO, OV_HI);
      chk("ov_hsel", bus_ov.Hsel, (dov < 0) ? 32'd0 : (32'd1 << dov));
      chk("ov_default", bus_ov.Hsel_default, (dov < 0) ? 32'd1 : 32'd0);
      @(negedge Hclk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_addr_decoder.md
AHB_ADDR_DECODER -- requirements
Module: ahb_addr_decoder

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, the number of decoded slave regions.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, the Haddr width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, the read-data width.
REQ-004 SHALL have parameter arrays BASE_ADDR/HIGH_ADDR [NUM_SLAVES], defaulting to the shared-package map, holding the half-open region bounds [BASE, HIGH).
REQ-005 SHALL have port Hclk  input  1  single bus clock; all state is rising-edge.
REQ-006 SHALL have port Hresetn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port Haddr  input  ADDR_WIDTH  address-phase address.
REQ-008 SHALL have port Htrans  input  2  transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-009 SHALL have port Region_en  input  NUM_SLAVES  per-region decode enable.
REQ-010 SHALL have ports Hrdata_s, Hreadyout_s and Hresp_s  input  NUM_SLAVES x (DATA_WIDTH / 1 / 1)  per-slave responses.
REQ-011 SHALL have port Hsel  output  NUM_SLAVES  one-hot-or-zero slave select.
REQ-012 SHALL have port Hsel_default  output  1  unmapped-address select.
REQ-013 SHALL have ports Hrdata, Hready and Hresp  output  DATA_WIDTH / 1 / 1  muxed master-side response.
REQ-014 SHALL have port Err_count  output  8  saturating count of default-slave ERROR responses.

Function
REQ-015 Decode SHALL be combinational: Hsel[i]=1 for the lowest i with Region_en[i]=1 and BASE_ADDR[i] <= Haddr < HIGH_ADDR[i]; all other bits 0.
REQ-016 Hsel_default SHALL be 1 exactly when Hsel is all-zero; Haddr==HIGH_ADDR[i] SHALL NOT match region i.
REQ-017 Hsel/Hsel_default SHALL follow Haddr regardless of Htrans.
REQ-018 A data-phase select register (slave index + default flag) SHALL load the current decode on each Hclk edge where Hready=1 and hold while Hready=0.
REQ-019 Hrdata/Hready/Hresp SHALL be muxed from the data-phase-selected slave; Region_en or Haddr changes SHALL NOT affect an in-flight data phase.
REQ-020 With default selected, Hrdata SHALL be 0.
REQ-021 Default-slave FSM states: DS_IDLE, DS_ERR1, DS_ERR2.
REQ-022 DS_IDLE -> DS_ERR1 when Hready=1, Hsel_default=1 and Htrans is NONSEQ/SEQ; otherwise remain in DS_IDLE.
REQ-023 DS_ERR1 SHALL drive Hready=0, Hresp=1 and go to DS_ERR2 unconditionally.
REQ-024 DS_ERR2 SHALL drive Hready=1, Hresp=1, then go to DS_ERR1 on a new qualifying default transfer, else DS_IDLE.
REQ-025 IDLE/BUSY to the default slave SHALL get a zero-wait OKAY response (Hready=1, Hresp=0).
REQ-026 Err_count SHALL increment on each DS_ERR1 entry and saturate at 255.
REQ-027 Overlapping enabled regions SHALL resolve to the lowest index; all regions disabled SHALL route every address to default.

Reset
REQ-028 Hresetn=0 SHALL immediately clear the data-phase select to default/no-transfer, FSM to DS_IDLE and Err_count to 0, giving Hready=1, Hresp=0, Hrdata=0.
REQ-029 Reset asserted in DS_ERR1/DS_ERR2 SHALL abort the ERROR response; the first post-reset cycle SHALL be DS_IDLE.

Structure
REQ-030 The shared package SHALL hold ADDR_WIDTH, DATA_WIDTH, NUM_SLAVES, BASE_ADDR/HIGH_ADDR arrays, the htrans_t enum, HRESP OKAY/ERROR constants and ds_state_t.
REQ-031 The default-slave FSM plus Err_count SHALL be one sub-module, ahb_default_slave; decode and mux SHALL stay in ahb_addr_decoder.

Verification
(Map: S0 0x0000_0000-0x0000_1000, S1 0x0000_1000-0x0000_2000, S2 0x1000_0000-0x2000_0000, S3 0x4000_0000-0x4000_0100, all enabled.)
REQ-032 Haddr=0x0000_0FFF then 0x0000_1000 -> Hsel=0001, then 0010; 0x4000_0100 -> Hsel=0000, Hsel_default=1.
REQ-033 NONSEQ to 0x3000_0000 -> next cycle Hready=0/Hresp=1, following cycle Hready=1/Hresp=1, Err_count=1; back-to-back second unmapped NONSEQ -> repeat, Err_count=2.
REQ-034 NONSEQ to S2 with Hreadyout_s[2]=0 for 3 cycles while Haddr moves to S0 -> Hready=0 for 3 cycles, Hrdata tracks Hrdata_s[2] until Hreadyout_s[2]=1.
REQ-035 Region_en=1110 with Haddr=0x0000_0010 -> Hsel_default=1; IDLE transfer there -> Hready=1, Hresp=0, Err_count unchanged.
REQ-036 Hresetn low during DS_ERR1 -> Hready=1, Hresp=0, Err_count=0 in the same cycle; 300 forced errors -> Err_count holds 255.
